// File: rtl/vga_pattern_sched.sv
// Test-pattern pixel source for the VGA path; pattern switches only at frame boundaries.
// Optional auto-cycling of patterns: compile with VGA_PATTERN_AUTO_CYCLE_EN defined.
module vga_pattern_sched #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int AUTO_FRAMES = 120
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  input  logic       i_h_disp,
  input  logic       i_v_disp,
  input  logic       i_btn_next,
  output logic [1:0] o_mode,
  output logic [1:0] o_r,
  output logic [1:0] o_g,
  output logic [1:0] o_b,
  output logic       o_frame_tick
);

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_t;

  mode_t       r_mode;
  logic [5:0]  r_rgb;
  logic        r_frame_tick;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [7:0]  r_frame_cnt;
  logic        r_pending;
  logic        r_btn_prev;
  logic        r_h_prev;
  logic        r_v_prev;

  logic        w_btn_edge;
  logic        w_boundary;
  logic        w_active;
  logic        w_auto_expire;
  logic        w_advance;
  logic [1:0]  w_scroll_hi;
  logic [5:0]  w_pat;
  logic        w_unused_params;

  // The position bounds are informational only; the counters follow the display flags.
  assign w_unused_params = ^{H_ACTIVE[0], V_ACTIVE[0], AUTO_FRAMES[0]};

  assign w_btn_edge = i_btn_next & ~r_btn_prev;
  assign w_boundary = i_pix_en & r_v_prev & ~i_v_disp;
  assign w_active   = i_h_disp & i_v_disp;
  // A request arriving on the boundary cycle itself is held for the next boundary.
  assign w_advance  = w_boundary & (r_pending | w_auto_expire);

  // Only bits [6:5] of the 10-bit scroll sum are displayed, so a 7-bit sum suffices.
  assign w_scroll_hi = 2'((r_x[6:0] + r_frame_cnt[6:0]) >> 5);

  always_comb begin
    w_pat = 6'd0;
    case (r_mode)
      MODE_BARS: begin
        case (r_x[9:7])
          3'd0:    w_pat = 6'b11_11_11;
          3'd1:    w_pat = 6'b11_00_00;
          3'd2:    w_pat = 6'b00_11_00;
          3'd3:    w_pat = 6'b00_00_11;
          default: w_pat = 6'b00_00_00;
        endcase
      end
      MODE_CHECKER: w_pat = (r_x[5] ^ r_y[5]) ? 6'b11_11_11 : 6'b00_00_00;
      MODE_SOLID:   w_pat = r_frame_cnt[7:2];
      MODE_SCROLL:  w_pat = {w_scroll_hi, r_y[6:5], 2'b01};
      default:      w_pat = 6'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mode       <= MODE_BARS;
      r_rgb        <= 6'd0;
      r_frame_tick <= 1'b0;
      r_x          <= 10'd0;
      r_y          <= 9'd0;
      r_frame_cnt  <= 8'd0;
      r_pending    <= 1'b0;
      r_btn_prev   <= 1'b0;
      r_h_prev     <= 1'b0;
      r_v_prev     <= 1'b0;
    end else begin
      r_btn_prev   <= i_btn_next;
      r_frame_tick <= w_boundary;
      if (w_boundary) begin
        r_pending   <= w_btn_edge;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (w_btn_edge) begin
        r_pending   <= 1'b1;
      end
      if (w_advance) begin
        r_mode <= mode_t'(r_mode + 2'd1);
      end
      if (i_pix_en) begin
        r_h_prev <= i_h_disp;
        r_v_prev <= i_v_disp;
        if (w_active) begin
          r_x   <= r_x + 10'd1;
          r_rgb <= w_pat;
        end else begin
          r_rgb <= 6'd0;
          if (!i_h_disp) begin
            r_x <= 10'd0;
          end
        end
        // The line counter steps on the trailing edge of each active line.
        if (!i_v_disp) begin
          r_y <= 9'd0;
        end else if (r_h_prev && !i_h_disp) begin
          r_y <= r_y + 9'd1;
        end
      end
    end
  end

`ifdef VGA_PATTERN_AUTO_CYCLE_EN
  localparam logic [7:0] AUTO_LAST = 8'(AUTO_FRAMES - 1);

  logic [7:0] r_auto_cnt;

  assign w_auto_expire = (r_auto_cnt == AUTO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_auto_cnt <= 8'd0;
    end else if (w_boundary) begin
      r_auto_cnt <= w_advance ? 8'd0 : r_auto_cnt + 8'd1;
    end
  end
`else
  assign w_auto_expire = 1'b0;
`endif

  assign o_mode       = r_mode;
  assign o_r          = r_rgb[5:4];
  assign o_g          = r_rgb[3:2];
  assign o_b          = r_rgb[1:0];
  assign o_frame_tick = r_frame_tick;

endmodule

// File: doc/vga_pattern_sched.md
# vga_pattern_sched

Pixel-source controller for the VGA output path. It drives the 2-bit-per-channel colour inputs of the VGA top from four built-in test patterns. It tracks the active-pixel position from the sync counter's display-enable flags and the divided pixel strobe. Pattern changes requested by a push-button are deferred to the next frame boundary, so a frame is never torn.

## Interface
- `H_ACTIVE`, 640: active pixels per line. Informational bound for the x counter.
- `V_ACTIVE`, 480: active lines per frame. Informational bound for the y counter.
- `AUTO_FRAMES`, 120: frames per pattern when auto-cycling is compiled in.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, synchronous, active-low.
- `pix_en`  in  1  one-`clk` pixel strobe at half rate, in phase with the divided VGA clock.
- `h_disp`  in  1  horizontal display-active flag from the sync counter.
- `v_disp`  in  1  vertical display-active flag from the sync counter.
- `btn_next`  in  1  debounced level; each rising edge requests the next pattern.
- `mode`  out  2  current pattern: 0 BARS, 1 CHECKER, 2 SOLID, 3 SCROLL.
- `R`, `G`, `B`  out  2 each  colour to the VGA top.
- `frame_tick`  out  1  one-`clk` pulse at each frame boundary.

## Operation
- **Position tracking.** `h_disp` and `v_disp` are sampled only on `pix_en` cycles into `h_prev` and `v_prev`.
  - x, 10 bits: on `pix_en` with `h_disp&v_disp`, x increments; on `pix_en` with `!h_disp`, x clears.
  - y, 9 bits: increments on `pix_en` when `h_prev&!h_disp&v_disp`; clears on `pix_en` with `!v_disp`.
- **Frame boundary.** Occurs on a `pix_en` cycle with `v_prev&!v_disp`. On that cycle:
  - `frame_tick`=1;
  - `frame_cnt` (8 bit, wraps 255→0) increments;
  - if `pending`=1, `mode` advances by one modulo 4 (3→0).
- **Request handling.**
  - `btn_prev` is sampled every `clk`; `btn_next&!btn_prev` sets `pending`.
  - The boundary clears `pending`, unless an edge arrives on the same cycle, in which case `pending` stays 1.
  - Any number of edges within one frame produce exactly one advance.
- **Pattern function.** f(mode,x,y,frame_cnt) gives {R,G,B}:
  - **BARS:** b=x[9:7]. b=0 → 3,3,3; 1 → 3,0,0; 2 → 0,3,0; 3 → 0,0,3; 4 and above → 0,0,0.
  - **CHECKER:** x[5]^y[5] gives 3,3,3, otherwise 0,0,0.
  - **SOLID:** R=frame_cnt[7:6], G=frame_cnt[5:4], B=frame_cnt[3:2].
  - **SCROLL:** s=x+frame_cnt (10 bit, wrap). R=s[6:5], G=y[6:5], B=1.
- **Colour register.**
  - On `pix_en` with `h_disp&v_disp`: {R,G,B} ← f using the pre-increment x and the current y, mode and frame_cnt.
  - On `pix_en` otherwise: {R,G,B} ← 0.
  - On non-`pix_en` cycles: {R,G,B} hold.
- **Reset** (`rst`=0 at a `clk` edge) sets all of the following; reset mid-frame therefore restarts cleanly with no spurious `frame_tick`:
  - `mode`=0 and R=G=B=0;
  - `frame_tick`=0;
  - x=0, y=0, `frame_cnt`=0;
  - `pending`=0;
  - `btn_prev`=0, `h_prev`=0, `v_prev`=0.

## Timing
- Colour latency: one `clk` after the `pix_en` cycle that samples the pixel. Valid for the following 2 `clk`.
- `mode` changes in the `clk` after the boundary `pix_en`. The first active pixel of the next frame uses the new mode.
- `frame_tick` is high for exactly one `clk` per frame.
- A button edge is registered within one `clk`. It takes effect at the next boundary, which is up to one frame away.
- No combinational path from any input to any output.

## Configuration
- `VGA_PATTERN_AUTO_CYCLE_EN` defined:
  - an 8-bit `auto_cnt` increments at each boundary;
  - at a boundary with `auto_cnt`==`AUTO_FRAMES`-1, `mode` advances exactly as if `pending`=1;
  - any advance, from button or auto, clears `auto_cnt`;
  - reset clears `auto_cnt`;
  - a button request and an auto expiry at the same boundary produce a single advance.
- Not defined: no `auto_cnt`; `AUTO_FRAMES` is unused; only the button advances `mode`.

## Test plan
- **Reset.** Hold `rst`=0 for 4 `clk` mid-line with `pix_en` toggling → `mode`=0, R=G=B=0, `frame_tick`=0. The first full frame after release shows no early tick.
- **BARS.** Active line in mode 0; sample output after x=0, 128, 256, 384, 512 → {3,3,3}, {3,0,0}, {0,3,0}, {0,0,3}, {0,0,0}. Output is 0 during `h_disp`=0.
- **CHECKER.** Press `btn_next` once mid-frame → `mode` stays 0 until the `v_disp` fall, then becomes 1. Pixel (32,0) → 3,3,3; pixel (32,32) → 0,0,0.
- **Request merging.** Three presses within one frame → single advance 1→2. A press on the exact boundary `pix_en` cycle with `pending`=0 → advance at the following boundary.
- **Wrap and SOLID.** Advance to mode 3 and press again → `mode`=0. In mode 2 after 200 boundaries (`frame_cnt`=200) → R=3, G=0, B=2.
- **Auto-cycle** (macro defined, `AUTO_FRAMES`=2, no presses) → `mode` steps 0→1→2 every 2 frames. With a simultaneous button request at an expiring boundary → exactly one step.
